cp0_regfile: RTL and testbench

Coprocessor-0 register file for the MIPS32 pipeline. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and serves MFC0 reads and MTC0 writes from the pipeline. It commits the exception-stage record (EPC, BadVAddr, ExcCode, BD, EXL) and ERET returns. It also runs the Count/Compare timer and folds the timer and hardware interrupt lines into Cause.IP.

---
 rtl/cpu_defs.sv | 26 ++
 rtl/cp0_timer.sv | 48 ++++
 rtl/cp0_regfile.sv | 155 +++++++++++++++
 tb/tb_cp0_regfile.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared MIPS32 core definitions: CP0 register numbers, Status/Cause bit
// positions and exception codes.
package cpu_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_BEV_BIT = 22;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_TI_BIT   = 30;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances at half the core clock and TI
// latches when an increment lands on Compare.
module cp0_timer
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        tick;
    logic        wr_count;
    logic        wr_compare;
    logic [31:0] count_inc;

    assign wr_count   = mtc0_we && (mtc0_addr == CP0_COUNT);
    assign wr_compare = mtc0_we && (mtc0_addr == CP0_COMPARE);
    assign count_inc  = count + 32'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick    <= 1'b0;
            count   <= 32'd0;
            compare <= 32'd0;
            ti      <= 1'b0;
        end else begin
            tick <= ~tick;
            // A software load of Count replaces this cycle's increment.
            if (wr_count)
                count <= mtc0_data;
            else if (tick)
                count <= count_inc;
            if (wr_compare)
                compare <= mtc0_data;
            // Writing Compare acknowledges the interrupt, even against a fresh match.
            if (wr_compare)
                ti <= 1'b0;
            else if (tick && !wr_count && (count_inc == compare))
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MFC0/MTC0 access, exception/ERET commit,
// interrupt folding into Cause.IP and the registered interrupt request.
module cp0_regfile
    import cpu_defs::*;
#(
    parameter logic [31:0] STATUS_RST    = 32'h0040_0000,
    parameter int          TIMER_IRQ_BIT = 7
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_data,
    input  logic        exception_occur,
    input  logic [31:0] exc_we,
    input  logic [4:0]  ExcCode,
    input  logic [31:0] EPC_in,
    input  logic [31:0] BadVAddr_in,
    input  logic        is_ds,
    input  logic        isERET,
    input  logic [5:0]  hardware_abortion,
    output logic [31:0] Status,
    output logic [31:0] Cause,
    output logic [31:0] EPC,
    output logic        interrupt_pending
);

    localparam int HW_TIMER_IDX = TIMER_IRQ_BIT - 2;

    logic [7:0]  im,       im_n;
    logic        exl,      exl_n;
    logic        ie,       ie_n;
    logic        bd,       bd_n;
    logic [4:0]  exccode,  exccode_n;
    logic [5:0]  ip_hw,    ip_hw_n;
    logic [1:0]  ip_sw,    ip_sw_n;
    logic [31:0] epc,      epc_n;
    logic [31:0] badvaddr, badvaddr_n;
    logic        pending_n;

    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;

    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        unused_exc_we;

    cp0_timer u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .mtc0_we   (mtc0_we),
        .mtc0_addr (mtc0_addr),
        .mtc0_data (mtc0_data),
        .count     (count),
        .compare   (compare),
        .ti        (ti)
    );

    assign wr_status     = mtc0_we && (mtc0_addr == CP0_STATUS);
    assign wr_cause      = mtc0_we && (mtc0_addr == CP0_CAUSE);
    assign wr_epc        = mtc0_we && (mtc0_addr == CP0_EPC);
    assign unused_exc_we = ^{exc_we[31:15], exc_we[13:9], exc_we[7:0]};

    always_comb begin
        im_n       = im;
        exl_n      = exl;
        ie_n       = ie;
        bd_n       = bd;
        exccode_n  = exccode;
        ip_sw_n    = ip_sw;
        epc_n      = epc;
        badvaddr_n = badvaddr;

        // Status and Cause are always claimed by an exception; MTC0 only wins when neither
        // the exception record nor ERET owns the register this cycle.
        if (exception_occur) begin
            exl_n     = 1'b1;
            exccode_n = ExcCode;
            bd_n      = is_ds;
        end else if (isERET) begin
            exl_n = 1'b0;
        end else if (wr_status) begin
            im_n  = mtc0_data[15:8];
            exl_n = mtc0_data[STATUS_EXL_BIT];
            ie_n  = mtc0_data[STATUS_IE_BIT];
        end

        if (!exception_occur && wr_cause)
            ip_sw_n = mtc0_data[9:8];

        // A nested exception keeps the original return address.
        if (exception_occur && exc_we[CP0_EPC]) begin
            if (!exl)
                epc_n = EPC_in;
        end else if (wr_epc) begin
            epc_n = mtc0_data;
        end

        if (exception_occur && exc_we[CP0_BADVADDR])
            badvaddr_n = BadVAddr_in;

        ip_hw_n               = hardware_abortion;
        ip_hw_n[HW_TIMER_IDX] = hardware_abortion[HW_TIMER_IDX] | ti;

        pending_n = (|({ip_hw_n, ip_sw_n} & im_n)) && ie_n && !exl_n;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im                <= STATUS_RST[15:8];
            exl               <= STATUS_RST[STATUS_EXL_BIT];
            ie                <= STATUS_RST[STATUS_IE_BIT];
            bd                <= 1'b0;
            exccode           <= 5'd0;
            ip_hw             <= 6'd0;
            ip_sw             <= 2'd0;
            epc               <= 32'd0;
            badvaddr          <= 32'd0;
            interrupt_pending <= 1'b0;
        end else begin
            im                <= im_n;
            exl               <= exl_n;
            ie                <= ie_n;
            bd                <= bd_n;
            exccode           <= exccode_n;
            ip_hw             <= ip_hw_n;
            ip_sw             <= ip_sw_n;
            epc               <= epc_n;
            badvaddr          <= badvaddr_n;
            interrupt_pending <= pending_n;
        end
    end

    assign Status = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
    assign Cause  = {bd, ti, 14'd0, ip_hw, ip_sw, 1'b0, exccode, 2'b00};
    assign EPC    = epc;

    always_comb begin
        mfc0_data = 32'd0;
        case (mfc0_addr)
            CP0_BADVADDR: mfc0_data = badvaddr;
            CP0_COUNT:    mfc0_data = count;
            CP0_COMPARE:  mfc0_data = compare;
            CP0_STATUS:   mfc0_data = Status;
            CP0_CAUSE:    mfc0_data = Cause;
            CP0_EPC:      mfc0_data = epc;
            default:      mfc0_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile with hand-computed expectations.
module tb_cp0_regfile;

    logic        clk;
    logic        resetn;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic        exception_occur;
    logic [31:0] exc_we;
    logic [4:0]  ExcCode;
    logic [31:0] EPC_in;
    logic [31:0] BadVAddr_in;
    logic        is_ds;
    logic        isERET;
    logic [5:0]  hardware_abortion;
    logic [31:0] Status;
    logic [31:0] Cause;
    logic [31:0] EPC;
    logic        interrupt_pending;

    int checks   = 0;
    int failures = 0;

    cp0_regfile dut (
        .clk               (clk),
        .resetn            (resetn),
        .mtc0_we           (mtc0_we),
        .mtc0_addr         (mtc0_addr),
        .mtc0_data         (mtc0_data),
        .mfc0_addr         (mfc0_addr),
        .mfc0_data         (mfc0_data),
        .exception_occur   (exception_occur),
        .exc_we            (exc_we),
        .ExcCode           (ExcCode),
        .EPC_in            (EPC_in),
        .BadVAddr_in       (BadVAddr_in),
        .is_ds             (is_ds),
        .isERET            (isERET),
        .hardware_abortion (hardware_abortion),
        .Status            (Status),
        .Cause             (Cause),
        .EPC               (EPC),
        .interrupt_pending (interrupt_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        mtc0_we   = 1'b1;
        mtc0_addr = addr;
        mtc0_data = data;
        cyc();
        mtc0_we   = 1'b0;
    endtask

    function automatic logic [31:0] rd(input logic [4:0] addr);
        mfc0_addr = addr;
        return 32'd0;
    endfunction

    task automatic mfc0(input logic [4:0] addr, output logic [31:0] val);
        mfc0_addr = addr;
        #1;
        val = mfc0_data;
    endtask

    logic [31:0] v;
    logic        seen;

    initial begin
        resetn = 1'b0; mtc0_we = 1'b0; mtc0_addr = '0; mtc0_data = '0;
        mfc0_addr = '0; exception_occur = 1'b0; exc_we = '0; ExcCode = '0;
        EPC_in = '0; BadVAddr_in = '0; is_ds = 1'b0; isERET = 1'b0;
        hardware_abortion = '0;
        #12 resetn = 1'b1;
        cyc();

        // Reset mid-operation, with an exception strobe pending
        mtc0(5'd12, 32'hFFFF_FFFF);
        mtc0(5'd9, 32'h0000_0055);
        exception_occur = 1'b1; exc_we = 32'h0000_7100; EPC_in = 32'hDEAD_0000;
        resetn = 1'b0;
        #1;
        check("rst_status", Status, 32'h0040_0000);
        check("rst_cause", Cause, 32'h0000_0000);
        check("rst_epc", EPC, 32'h0000_0000);
        check("rst_pending", {31'd0, interrupt_pending}, 32'd0);
        mfc0(5'd9, v);  check("rst_count", v, 32'd0);
        mfc0(5'd12, v); check("rst_mfc0_status", v, 32'h0040_0000);
        cyc();
        check("rst_hold_epc", EPC, 32'h0000_0000);
        exception_occur = 1'b0; exc_we = '0;
        #2 resetn = 1'b1;
        cyc();
        mfc0(5'd3, v); check("unmapped_read", v, 32'd0);

        // Exception then nested exception then ERET
        exception_occur = 1'b1; exc_we = 32'h0000_7100; ExcCode = 5'h0C;
        EPC_in = 32'hBFC0_0100; is_ds = 1'b1;
        cyc();
        exception_occur = 1'b0;
        check("exc_cause", Cause, 32'h8000_0030);
        check("exc_epc", EPC, 32'hBFC0_0100);
        check("exc_status", Status, 32'h0040_0002);
        exception_occur = 1'b1; ExcCode = 5'h04; EPC_in = 32'h0000_1111; is_ds = 1'b0;
        cyc();
        exception_occur = 1'b0;
        check("nested_epc", EPC, 32'hBFC0_0100);
        check("nested_cause", Cause, 32'h0000_0010);
        isERET = 1'b1;
        cyc();
        isERET = 1'b0;
        check("eret_status", Status, 32'h0040_0000);

        // MTC0 Status / Cause and interrupt request
        mtc0(5'd12, 32'hFFFF_FFFF);
        check("status_mask", Status, 32'h0040_FF03);
        check("pend_exl_blocks", {31'd0, interrupt_pending}, 32'd0);
        mtc0(5'd12, 32'h0000_FF01);
        check("status_ie", Status, 32'h0040_FF01);
        check("pend_no_ip", {31'd0, interrupt_pending}, 32'd0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        check("cause_sw_ip", Cause, 32'h0000_0310);
        check("pend_sw_ip", {31'd0, interrupt_pending}, 32'd1);
        mtc0(5'd13, 32'h0000_0000);
        mtc0(5'd12, 32'h0000_0000);
        mfc0(5'd12, v); check("mfc0_status_cleared", v, 32'h0040_0000);

        // Hardware interrupt lines
        hardware_abortion = 6'b100001;
        cyc();
        check("hw_ip", Cause & 32'h0000_FF00, 32'h0000_8400);
        hardware_abortion = 6'b000000;
        cyc();
        check("hw_ip_clear", Cause & 32'h0000_FF00, 32'h0000_0000);

        // Timer
        mtc0(5'd11, 32'd10);
        mtc0(5'd9, 32'd5);
        mfc0(5'd9, v); check("count_load", v, 32'd5);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (Cause[30]) seen = 1'b1;
            else cyc();
        end
        check("ti_set", {31'd0, seen}, 32'd1);
        mfc0(5'd9, v); check("ti_count", v, 32'd10);
        cyc();
        check("ti_ip7", {31'd0, Cause[15]}, 32'd1);
        mtc0(5'd11, 32'd20);
        check("ti_clear", {31'd0, Cause[30]}, 32'd0);
        mfc0(5'd11, v); check("compare_read", v, 32'd20);

        // Collisions
        exception_occur = 1'b1; exc_we = 32'h0000_0100; BadVAddr_in = 32'h1234_5673;
        ExcCode = 5'h05;
        mtc0(5'd8, 32'hDEAD_BEEF);
        exception_occur = 1'b0;
        mfc0(5'd8, v); check("coll_badvaddr", v, 32'h1234_5673);
        exception_occur = 1'b1; exc_we = 32'h0000_0000;
        mtc0(5'd14, 32'h0000_00A0);
        exception_occur = 1'b0;
        check("coll_epc_mtc0", EPC, 32'h0000_00A0);
        isERET = 1'b1;
        cyc();
        isERET = 1'b0;
        check("eret_clear", {31'd0, Status[1]}, 32'd0);
        exception_occur = 1'b1; isERET = 1'b1;
        cyc();
        exception_occur = 1'b0; isERET = 1'b0;
        check("coll_exc_eret", {31'd0, Status[1]}, 32'd1);
        mtc0(5'd8, 32'h0000_0000);
        mfc0(5'd8, v); check("badvaddr_ro", v, 32'h1234_5673);

        // Count wrap without a spurious match
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'hFFFF_FFFF);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            mfc0(5'd9, v);
            if (v == 32'd0) seen = 1'b1;
            else cyc();
        end
        check("wrap_zero", {31'd0, seen}, 32'd1);
        check("wrap_no_ti", {31'd0, Cause[30]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
